// File: rtl/rr_grant_scheduler_if.sv
// Request/grant/release bundle between requesting engines and the scheduler.
interface rr_grant_scheduler_if #(
    parameter int N_REQ = 4,
    parameter int ID_W  = $clog2(N_REQ)
);
    logic [N_REQ-1:0] req;
    logic [N_REQ-1:0] done;
    logic             rr_mode;
    logic [N_REQ-1:0] grant;
    logic             grant_valid;
    logic [ID_W-1:0]  grant_id;
    logic             timeout;

    modport master (
        output req, done, rr_mode,
        input  grant, grant_valid, grant_id, timeout
    );

    modport slave (
        input  req, done, rr_mode,
        output grant, grant_valid, grant_id, timeout
    );
endinterface

// File: rtl/rr_grant_scheduler.sv
// Locks one shared resource to a single requester until release or hold timeout,
// with a one-cycle turnaround gap; fixed-priority or round-robin arbitration.
module rr_grant_scheduler #(
    parameter int N_REQ    = 4,
    parameter int MAX_HOLD = 16,
    parameter int ID_W     = $clog2(N_REQ)
) (
    input logic                 clk,
    input logic                 rst_n,
    rr_grant_scheduler_if.slave bus
);

    localparam int HOLD_W = $clog2(MAX_HOLD);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [N_REQ-1:0]   grant_q, grant_d;
    logic               grantValid_q, grantValid_d;
    logic [ID_W-1:0]    grantId_q, grantId_d;
    logic               timeout_q, timeout_d;
    logic [HOLD_W-1:0]  holdCnt_q, holdCnt_d;
    logic [ID_W-1:0]    lastId_q, lastId_d;

    logic               anyReq;
    logic               foundHi;
    logic [ID_W-1:0]    winFixed;
    logic [ID_W-1:0]    winHi;
    logic [ID_W-1:0]    winner;
    logic               ownerRelease;
    logic               holdExpired;

    // Descending scan: the last hit is the lowest index. Round-robin prefers the
    // lowest requester above lastId, otherwise wraps to the lowest overall.
    always_comb begin
        anyReq   = |bus.req;
        foundHi  = 1'b0;
        winFixed = '0;
        winHi    = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (bus.req[i]) begin
                winFixed = ID_W'(i);
                if (ID_W'(i) > lastId_q) begin
                    winHi   = ID_W'(i);
                    foundHi = 1'b1;
                end
            end
        end
        winner = (bus.rr_mode && foundHi) ? winHi : winFixed;
    end

    assign ownerRelease = bus.done[grantId_q] || !bus.req[grantId_q];
    assign holdExpired  = (holdCnt_q == HOLD_W'(MAX_HOLD - 1));

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        grantValid_d = grantValid_q;
        grantId_d    = grantId_q;
        timeout_d    = 1'b0;
        holdCnt_d    = holdCnt_q;
        lastId_d     = lastId_q;

        unique case (state_q)
            IDLE, GAP: begin
                holdCnt_d = '0;
                if (anyReq) begin
                    state_d      = GRANT;
                    grant_d      = {{(N_REQ-1){1'b0}}, 1'b1} << winner;
                    grantValid_d = 1'b1;
                    grantId_d    = winner;
                end else begin
                    state_d      = IDLE;
                    grant_d      = '0;
                    grantValid_d = 1'b0;
                    grantId_d    = '0;
                end
            end
            GRANT: begin
                if (ownerRelease || holdExpired) begin
                    state_d      = GAP;
                    grant_d      = '0;
                    grantValid_d = 1'b0;
                    grantId_d    = '0;
                    lastId_d     = grantId_q;
                    holdCnt_d    = '0;
                    // A release in the expiring cycle is a normal release, not a timeout.
                    timeout_d    = !ownerRelease;
                end else begin
                    holdCnt_d = holdCnt_q + 1'b1;
                end
            end
            default: begin
                state_d      = IDLE;
                grant_d      = '0;
                grantValid_d = 1'b0;
                grantId_d    = '0;
                holdCnt_d    = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            grantValid_q <= 1'b0;
            grantId_q    <= '0;
            timeout_q    <= 1'b0;
            holdCnt_q    <= '0;
            lastId_q     <= ID_W'(N_REQ - 1);
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            grantValid_q <= grantValid_d;
            grantId_q    <= grantId_d;
            timeout_q    <= timeout_d;
            holdCnt_q    <= holdCnt_d;
            lastId_q     <= lastId_d;
        end
    end

    assign bus.grant       = grant_q;
    assign bus.grant_valid = grantValid_q;
    assign bus.grant_id    = grantId_q;
    assign bus.timeout     = timeout_q;

endmodule

// File: tb/tb_rr_grant_scheduler.sv
// Directed-vector bench for rr_grant_scheduler with hand-computed expectations.
module tb_rr_grant_scheduler;

    logic clk;
    logic rst_n;
    int   checkCount;
    int   errorCount;

    rr_grant_scheduler_if #(.N_REQ(4)) bus ();

    rr_grant_scheduler #(
        .N_REQ   (4),
        .MAX_HOLD(16)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic checkGrant(input string tag, input int expGrant, input int expId, input int expTimeout);
        checkOutput({tag, ".grant"},       32'(bus.grant),       32'(expGrant));
        checkOutput({tag, ".grant_valid"}, 32'(bus.grant_valid), (expGrant != 0) ? 32'd1 : 32'd0);
        checkOutput({tag, ".grant_id"},    32'(bus.grant_id),    32'(expId));
        checkOutput({tag, ".timeout"},     32'(bus.timeout),     32'(expTimeout));
    endtask

    task automatic applyStimulus(input logic [3:0] reqV, input logic [3:0] doneV, input logic rrV);
        bus.req     = reqV;
        bus.done    = doneV;
        bus.rr_mode = rrV;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset(input string tag);
        applyStimulus(4'b0000, 4'b0000, 1'b0);
        rst_n = 1'b0;
        #12;
        checkGrant(tag, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        checkCount = 0;
        errorCount = 0;
        rst_n      = 1'b1;
        applyStimulus(4'b0000, 4'b0000, 1'b0);
        #2;

        // Idle after reset
        doReset("reset");
        for (int c = 0; c < 5; c++) begin
            tick();
            checkGrant($sformatf("idle%0d", c), 0, 0, 0);
        end

        // Fixed priority, release via done, regrant after one-cycle gap
        doReset("reset2");
        applyStimulus(4'b1010, 4'b0000, 1'b0);
        tick();
        checkGrant("fix_c1", 4'b0010, 1, 0);
        tick();
        checkGrant("fix_c2", 4'b0010, 1, 0);
        tick();
        checkGrant("fix_c3", 4'b0010, 1, 0);
        applyStimulus(4'b1010, 4'b0010, 1'b0);
        tick();
        applyStimulus(4'b1010, 4'b0000, 1'b0);
        checkGrant("fix_gap", 0, 0, 0);
        tick();
        checkGrant("fix_regrant", 4'b0010, 1, 0);

        // Round-robin rotation with all requesters active
        doReset("reset3");
        applyStimulus(4'b1111, 4'b0000, 1'b1);
        for (int n = 0; n < 5; n++) begin
            int id;
            id = n % 4;
            tick();
            checkGrant($sformatf("rr%0d_first", n), 1 << id, id, 0);
            tick();
            checkGrant($sformatf("rr%0d_second", n), 1 << id, id, 0);
            applyStimulus(4'b1111, 4'(1 << id), 1'b1);
            tick();
            applyStimulus(4'b1111, 4'b0000, 1'b1);
            checkGrant($sformatf("rr%0d_gap", n), 0, 0, 0);
        end

        // Hold timeout after exactly 16 cycles
        doReset("reset4");
        applyStimulus(4'b0001, 4'b0000, 1'b1);
        for (int c = 0; c < 16; c++) begin
            tick();
            checkGrant($sformatf("hold%0d", c), 4'b0001, 0, 0);
        end
        tick();
        checkGrant("timeout_gap", 0, 0, 1);
        tick();
        checkGrant("timeout_regrant", 4'b0001, 0, 0);

        // Non-owner done is ignored; release in the expiring cycle beats timeout
        applyStimulus(4'b0001, 4'b0100, 1'b1);
        tick();
        applyStimulus(4'b0001, 4'b0000, 1'b1);
        checkGrant("nonowner_done", 4'b0001, 0, 0);
        for (int c = 0; c < 14; c++) tick();
        checkGrant("hold15", 4'b0001, 0, 0);
        applyStimulus(4'b0001, 4'b0001, 1'b1);
        tick();
        applyStimulus(4'b0001, 4'b0000, 1'b1);
        checkGrant("release_wins", 0, 0, 0);
        tick();
        checkGrant("after_release", 4'b0001, 0, 0);

        // Asynchronous reset mid-grant, then round-robin restarts from index 0
        #3;
        rst_n = 1'b0;
        #1;
        checkGrant("async_reset", 0, 0, 0);
        applyStimulus(4'b1000, 4'b0000, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        checkGrant("post_reset", 4'b1000, 3, 0);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
